interact_defaults: RTL

INTERACT_DEFAULTS -- requirements
Module: interact_defaults

---
 rtl/interact_defaults_if.sv | 33 +++
 rtl/interact_defaults.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/interact_defaults_if.sv
// Host bridge bundle between the defaults sequencer and the bridge responder.
// Latency: none, plain wires grouped for port connection.
// Backpressure: host_busy from the host side stalls strobe issue in the sequencer.
// Signals:
//   bridge_addr/bridge_wr/bridge_wr_data/bridge_rd : sequencer -> responder
//   bridge_rd_data                                  : responder -> sequencer, valid 1 cycle after bridge_rd
//   host_busy                                       : host -> sequencer, host bridge access in progress
interface interact_defaults_if;
  logic [31:0] bridge_addr;
  logic        bridge_wr;
  logic [31:0] bridge_wr_data;
  logic        bridge_rd;
  logic [31:0] bridge_rd_data;
  logic        host_busy;

  modport master (
    output bridge_addr,
    output bridge_wr,
    output bridge_wr_data,
    output bridge_rd,
    input  bridge_rd_data,
    input  host_busy
  );

  modport slave (
    input  bridge_addr,
    input  bridge_wr,
    input  bridge_wr_data,
    input  bridge_rd,
    output bridge_rd_data,
    output host_busy
  );
endinterface

// File: rtl/interact_defaults.sv
// Replays a fixed 5-entry table of power-up settings over the host bridge, optionally reads back and compares.
// Latency: first write strobe visible 2 edges after reset release (sampled high on the 3rd); GAP idle cycles between strobes.
// Backpressure: host_busy holds the FSM in WRITE/READ without strobing; start is ignored while busy.
// Ports:
//   clk_74a, reset_n        : clock, async active-low reset
//   start                   : replay request, level-sampled in IDLE/DONE
//   bridge (master modport) : addr / wr / wr_data / rd out, rd_data / host_busy in
//   busy, done, error       : status (done and error sticky until the next start)
//   err_index               : table index of the first readback mismatch
module interact_defaults #(
  parameter int unsigned GAP       = 4,
  parameter int unsigned VERIFY    = 1,
  parameter logic [31:0] DEF_DIP   = 32'h0,
  parameter logic [31:0] DEF_MOD   = 32'h0,
  parameter logic [31:0] DEF_FLT   = 32'h0,
  parameter logic [31:0] DEF_EXT   = 32'h0,
  parameter logic [15:0] DEF_NVRAM = 16'h0
) (
  input  logic                       clk_74a,
  input  logic                       reset_n,
  input  logic                       start,
  interact_defaults_if.master        bridge,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [2:0]                 err_index
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WGAP  = 3'd2,
    READ  = 3'd3,
    RWAIT = 3'd4,
    CHECK = 3'd5,
    DONE  = 3'd6
  } state_e;

  localparam logic [2:0] LAST_IDX = 3'd4;
  localparam logic [3:0] GAP_M1   = 4'(GAP - 1);

  // Entry i lives at 0xF{i+1}000000.
  function automatic logic [31:0] tbl_addr(input logic [2:0] i);
    tbl_addr = {4'hF, 1'b0, i + 3'd1, 24'h0};
  endfunction

  function automatic logic [31:0] tbl_data(input logic [2:0] i);
    case (i)
      3'd0:    tbl_data = DEF_DIP;
      3'd1:    tbl_data = DEF_MOD;
      3'd2:    tbl_data = DEF_FLT;
      3'd3:    tbl_data = DEF_EXT;
      3'd4:    tbl_data = {16'h0, DEF_NVRAM};
      default: tbl_data = 32'h0;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pending_q, pending_d;
  // WGAP is shared by both passes; this selects where it exits to.
  logic        rd_phase_q, rd_phase_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [2:0]  err_idx_q, err_idx_d;

  // State and output registers.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      cnt_q      <= 4'd0;
      pending_q  <= 1'b1;
      rd_phase_q <= 1'b0;
      rdata_q    <= 32'h0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_idx_q  <= 3'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      rd_phase_q <= rd_phase_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_idx_q  <= err_idx_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    rd_phase_d = rd_phase_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (pending_q || start) begin
          state_d    = WRITE;
          idx_d      = 3'd0;
          pending_d  = 1'b0;
          rd_phase_d = 1'b0;
        end
      end
      WRITE: begin
        if (!bridge.host_busy) begin
          state_d = WGAP;
          cnt_d   = 4'd0;
        end
      end
      WGAP: begin
        if (cnt_q == GAP_M1) begin
          cnt_d = 4'd0;
          if (rd_phase_q) begin
            idx_d   = idx_q + 3'd1;
            state_d = READ;
          end else if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + 3'd1;
            state_d = WRITE;
          end else if (VERIFY != 0) begin
            idx_d      = 3'd0;
            rd_phase_d = 1'b1;
            state_d    = READ;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      READ: begin
        if (!bridge.host_busy) begin
          state_d = RWAIT;
          cnt_d   = 4'd0;
        end
      end
      RWAIT: begin
        // Read data is valid in the second RWAIT cycle; capture it so CHECK
        // does not depend on the responder holding its bus.
        if (cnt_q == 4'd1) begin
          cnt_d   = 4'd0;
          rdata_d = bridge.bridge_rd_data;
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      CHECK: begin
        if (idx_q != LAST_IDX) begin
          state_d = WGAP;
          cnt_d   = 4'd0;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_d    = WRITE;
          idx_d      = 3'd0;
          rd_phase_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = 1'b0;
    rd_d      = 1'b0;
    error_d   = error_q;
    err_idx_d = err_idx_q;
    busy_d    = (state_d != IDLE) && (state_d != DONE);
    done_d    = (state_d == DONE);
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          error_d   = 1'b0;
          err_idx_d = 3'd0;
        end
      end
      WRITE: begin
        if (!bridge.host_busy) begin
          wr_d    = 1'b1;
          addr_d  = tbl_addr(idx_q);
          wdata_d = tbl_data(idx_q);
        end
      end
      READ: begin
        if (!bridge.host_busy) begin
          rd_d   = 1'b1;
          addr_d = tbl_addr(idx_q);
        end
      end
      CHECK: begin
        // Only the first mismatch is recorded; the pass always runs to the end.
        if ((rdata_q != tbl_data(idx_q)) && !error_q) begin
          error_d   = 1'b1;
          err_idx_d = idx_q;
        end
      end
      default: ;
    endcase
  end

  assign bridge.bridge_addr    = addr_q;
  assign bridge.bridge_wr_data = wdata_q;
  assign bridge.bridge_wr      = wr_q;
  assign bridge.bridge_rd      = rd_q;
  assign busy                  = busy_q;
  assign done                  = done_q;
  assign error                 = error_q;
  assign err_index             = err_idx_q;

endmodule
